// File: rtl/keypad_debounce_repeat.sv
// Keypad debouncer: confirms a stable scan code, latches it, and emits
// one-cycle press/repeat (enable) and release strobes with optional auto-repeat.
module keypad_debounce_repeat #(
   parameter int          CODE_W        = 8,
   parameter int          DB_CYCLES     = 3,
   parameter int          REPEAT_EN     = 0,
   parameter int          REPEAT_DELAY  = 8,
   parameter int          REPEAT_PERIOD = 4,
   parameter logic [31:0] RESET_CODE    = 32'h0F
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [CODE_W-1:0] sig_in,
   input  logic              key_pressed,
   output logic [CODE_W-1:0] sig_out,
   output logic              enable,
   output logic              release_pulse,
   output logic              held
);

   localparam int DB_W    = $clog2(DB_CYCLES + 1);
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = $clog2(RPT_MAX + 1);

   localparam logic [CODE_W-1:0] RST_CODE = CODE_W'(RESET_CODE);
   localparam logic [DB_W-1:0]   DB_LAST  = DB_W'(DB_CYCLES - 1);
   localparam logic [RPT_W-1:0]  DLY_LAST = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0]  PER_LAST = RPT_W'(REPEAT_PERIOD - 1);

   typedef enum logic [1:0] {S_IDLE, S_PRESS, S_HELD, S_REL} state_t;

   state_t            state_q;
   logic [CODE_W-1:0] cand_q;
   logic [DB_W-1:0]   db_q;
   logic [RPT_W-1:0]  rpt_q;
   logic              rpt_first_q;
   logic [CODE_W-1:0] sig_out_q;
   logic              enable_q;
   logic              rel_q;
   logic              held_q;
   logic              rpt_last;

   // First repeat waits the long delay, subsequent ones the shorter period.
   assign rpt_last = rpt_first_q ? (rpt_q == DLY_LAST) : (rpt_q == PER_LAST);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         cand_q      <= '0;
         db_q        <= '0;
         rpt_q       <= '0;
         rpt_first_q <= 1'b1;
         sig_out_q   <= RST_CODE;
         enable_q    <= 1'b0;
         rel_q       <= 1'b0;
         held_q      <= 1'b0;
      end else begin
         enable_q <= 1'b0;
         rel_q    <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (key_pressed) begin
                  cand_q  <= sig_in;
                  db_q    <= '0;
                  state_q <= S_PRESS;
               end
            end
            S_PRESS: begin
               if (!key_pressed || sig_in != cand_q) begin
                  state_q <= S_IDLE;
                  db_q    <= '0;
               end else if (db_q == DB_LAST) begin
                  state_q     <= S_HELD;
                  sig_out_q   <= cand_q;
                  enable_q    <= 1'b1;
                  rpt_q       <= '0;
                  rpt_first_q <= 1'b1;
                  held_q      <= 1'b1;
               end else begin
                  db_q <= db_q + DB_W'(1);
               end
            end
            S_HELD: begin
               // A different code while held (roll-over) is simply not acted on.
               if (!key_pressed) begin
                  state_q <= S_REL;
                  db_q    <= '0;
               end else if (REPEAT_EN != 0) begin
                  if (rpt_last) begin
                     enable_q    <= 1'b1;
                     rpt_q       <= '0;
                     rpt_first_q <= 1'b0;
                  end else begin
                     rpt_q <= rpt_q + RPT_W'(1);
                  end
               end
            end
            S_REL: begin
               if (key_pressed) begin
                  state_q <= S_HELD;
               end else if (db_q == DB_LAST) begin
                  state_q <= S_IDLE;
                  rel_q   <= 1'b1;
                  held_q  <= 1'b0;
               end else begin
                  db_q <= db_q + DB_W'(1);
               end
            end
            default: begin
               state_q <= S_IDLE;
               db_q    <= '0;
               rpt_q   <= '0;
               held_q  <= 1'b0;
            end
         endcase
      end
   end

   assign sig_out       = sig_out_q;
   assign enable        = enable_q;
   assign release_pulse = rel_q;
   assign held          = held_q;

endmodule

// File: doc/keypad_debounce_repeat.md
# keypad_debounce_repeat

Parametrised keypad debouncer between the keypad scanner and the digit/display logic. It confirms a press only after the key code has been stable for a programmable number of scan-clock samples, and latches that code. It emits one-cycle press, auto-repeat and release strobes. Glitches, code changes during debounce and release bounce are all rejected.

## Interface
- CODE_W, 8: width of the scanned key code.
- DB_CYCLES, 3: extra consecutive matching samples needed to confirm a press or a release; must be ≥ 1.
- REPEAT_EN, 0: when 1, a held key generates auto-repeat strobes.
- REPEAT_DELAY, 8: HELD cycles before the first repeat strobe; must be ≥ 1.
- REPEAT_PERIOD, 4: cycles between later repeat strobes; must be ≥ 1.
- RESET_CODE, 8'h0F: value of sig_out after reset; bits above CODE_W are truncated.
- clk, input, 1: scan clock; all logic is on its rising edge.
- reset, input, 1: synchronous, active-low reset.
- sig_in, input, CODE_W: raw row/column code from the scanner.
- key_pressed, input, 1: raw "some key down" flag from the scanner.
- sig_out, output, CODE_W: last confirmed key code, registered.
- enable, output, 1: one-cycle strobe on a confirmed press or a repeat, registered.
- release_pulse, output, 1: one-cycle strobe on a confirmed release, registered.
- held, output, 1: high while in HELD or REL_DB, registered.

## Operation
- States: IDLE, PRESS_DB, HELD, REL_DB.
- Registers:
  - cand: CODE_W-bit candidate code.
  - db_cnt: sized $clog2(DB_CYCLES+1).
  - rpt_cnt: sized $clog2(max(REPEAT_DELAY,REPEAT_PERIOD)+1).
- IDLE:
  - key_pressed=1: cand<=sig_in, db_cnt<=0, go to PRESS_DB.
  - Otherwise stay.
- PRESS_DB:
  - key_pressed=0 or sig_in≠cand: go to IDLE, db_cnt<=0, no strobe (glitch rejected).
  - Match and db_cnt==DB_CYCLES-1: go to HELD, sig_out<=cand, enable<=1, rpt_cnt<=0.
  - Match otherwise: db_cnt++.
- HELD:
  - key_pressed=0: go to REL_DB, db_cnt<=0.
  - key_pressed=1 with sig_in≠sig_out (second key or roll-over): ignored, no new press, sig_out unchanged.
  - REPEAT_EN=1, first repeat: when rpt_cnt==REPEAT_DELAY-1, enable<=1 and rpt_cnt<=0.
  - Later repeats: each time rpt_cnt==REPEAT_PERIOD-1, enable<=1 and rpt_cnt<=0. A flag register selects DELAY vs PERIOD.
  - REPEAT_EN=0: rpt_cnt frozen at 0.
- REL_DB:
  - key_pressed=1: back to HELD with no strobe (release bounce). rpt_cnt is not cleared, so repeat timing resumes.
  - key_pressed=0 and db_cnt==DB_CYCLES-1: go to IDLE, release_pulse<=1.
  - Otherwise db_cnt++.
- Counters never wrap: each is cleared on the compare match or on state entry.
- Unused state encodings go to IDLE on the next edge.
- Reset (reset=0 at an edge, in any state, mid-debounce included):
  - state=IDLE, all counters 0, cand=0.
  - sig_out=RESET_CODE, enable=0, release_pulse=0, held=0.

## Timing
- A press needs DB_CYCLES+1 consecutive edges sampling key_pressed=1 with an identical sig_in. Let the first such edge be edge 0.
  - HELD is entered and enable/sig_out update at edge DB_CYCLES.
  - enable is high for exactly the following cycle.
- sig_out changes only on the same edge that raises enable for a press; repeats leave it unchanged.
- A release needs DB_CYCLES+1 consecutive edges sampling key_pressed=0 from HELD. release_pulse is high for the cycle after the confirming edge.
- First repeat: enable rises REPEAT_DELAY edges after the press edge. Later repeats follow every REPEAT_PERIOD edges.
- enable and release_pulse are never high in the same cycle.
- No combinational path from inputs to outputs.

## Test plan
1. **Reset.** Hold reset=0 for 2 edges with key_pressed=1 → sig_out=8'h0F, enable=0, release_pulse=0, held=0. After release, a press starts from IDLE.
2. **Clean press** (DB_CYCLES=3). sig_in=8'h12, key_pressed=1 for 4+ edges → exactly one enable pulse in the cycle after edge 3, sig_out=8'h12, held=1.
3. **Glitch.** key_pressed=1 for 2 edges, then 0 → no enable, sig_out unchanged. Same result if sig_in changes 8'h12→8'h14 at edge 2; the 8'h14 press then needs a fresh 4 edges.
4. **Release bounce.** From HELD, key_pressed 0 for 2 edges, 1 for 1, then 0 for 4 → single release_pulse at the end, no extra enable.
5. **Auto-repeat** (REPEAT_EN=1, REPEAT_DELAY=8, REPEAT_PERIOD=4). Hold 8'h21 for 20 edges → enable pulses at press edge P, P+8, P+12, P+16. sig_out stays 8'h21.
6. **Reset mid-debounce.** Assert reset while in PRESS_DB (db_cnt=2) → no enable, returns to IDLE. A subsequent press needs the full 4 edges.
